// File: rtl/lfsr_pkg.sv
// Shared types and constants for the lfsr_seq pseudo-random source.
// Optional period monitor: define LFSR_PERIOD_MON_EN.
package lfsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lfsr_state_e;

    localparam logic [3:0] DEFAULT_TAPS_4 = 4'b1100;

    // Masks for x^n + ... + 1 with bit n-1 as the x^n tap
    function automatic logic [7:0] max_taps(input int width);
        logic [7:0] m;
        m = 8'h00;
        case (width)
            3:       m = 8'b0000_0110;
            4:       m = 8'b0000_1100;
            5:       m = 8'b0001_0100;
            6:       m = 8'b0011_0000;
            7:       m = 8'b0110_0000;
            8:       m = 8'b1011_1000;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step: shift toward MSB, feedback into bit 0.
// Combinational; shared by single- and multi-step sequencers.
module lfsr_step #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_state
);

    logic w_fb;

    assign w_fb    = ^(i_state & TAPS);
    assign o_state = {i_state[WIDTH-2:0], w_fb};

endmodule

// File: rtl/lfsr_seq.sv
// Parametrised LFSR with seed load, free-run and counted-run modes.
// Period monitor (wrap output) built only with LFSR_PERIOD_MON_EN.
import lfsr_pkg::*;

module lfsr_seq #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS_4),
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
    parameter int               CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             wrap
);

    lfsr_state_e      r_fsm;
    lfsr_state_e      w_fsm_nxt;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_state_nxt;
    logic [WIDTH-1:0] w_stepped;
    logic [CNT_W-1:0] r_left;
    logic [CNT_W-1:0] w_left_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_step;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .i_state (r_state),
        .o_state (w_stepped)
    );

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_left_nxt  = r_left;
        w_done_nxt  = 1'b0;
        w_step      = 1'b0;
        if (load) begin
            // A zero seed would lock the register; force a nonzero one
            w_state_nxt = (seed == '0) ? WIDTH'(1) : seed;
            w_fsm_nxt   = IDLE;
        end else begin
            unique case (r_fsm)
                RUN: begin
                    w_step      = 1'b1;
                    w_state_nxt = w_stepped;
                    w_left_nxt  = r_left - CNT_W'(1);
                    if (r_left == CNT_W'(1)) begin
                        w_fsm_nxt  = IDLE;
                        w_done_nxt = 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        if (count == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_fsm_nxt  = RUN;
                            w_left_nxt = count;
                        end
                    end else if (en) begin
                        w_step      = 1'b1;
                        w_state_nxt = w_stepped;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_state <= RESET_SEED;
            r_left  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_left  <= w_left_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy     = (r_fsm == RUN);
    assign done     = r_done;
    assign data_out = r_state;

`ifdef LFSR_PERIOD_MON_EN
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_period;
    logic             r_wrap;
    logic             w_hit;

    assign w_hit = w_step && (w_stepped == r_ref);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref    <= RESET_SEED;
            r_period <= '0;
            r_wrap   <= 1'b0;
        end else if (load) begin
            r_ref    <= w_state_nxt;
            r_period <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= w_hit;
            if (w_hit) begin
                r_period <= '0;
            end else if (w_step) begin
                r_period <= r_period + WIDTH'(1);
            end
        end
    end

    assign wrap = r_wrap;
`else
    assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq.sv
// Scoreboard bench for lfsr_seq: directed plan plus random traffic.
// Expected values come from an arithmetic reference model.
`timescale 1ns/1ps
module tb_lfsr_seq;
    import lfsr_pkg::*;

    localparam int         W  = 4;
    localparam int         CW = 8;
    localparam logic [W-1:0] TP = DEFAULT_TAPS_4;
`ifdef LFSR_PERIOD_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, load, en, start;
    logic [W-1:0]  seed;
    logic [CW-1:0] count;
    logic          busy, done, wrap;
    logic [W-1:0]  data_out;

    always #5 clk = ~clk;

    lfsr_seq #(
        .WIDTH      (W),
        .TAPS       (TP),
        .RESET_SEED (4'd1),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .seed     (seed),
        .en       (en),
        .start    (start),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .wrap     (wrap)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
        logic         dn;
        logic         wr;
    } exp_t;

    exp_t q[$];
    exp_t x;
    int   vectors = 0;
    int   errors  = 0;

    int m_state = 1;
    int m_ref   = 1;
    int m_left  = 0;
    bit m_run   = 0;
    bit m_done  = 0;
    bit m_wrap  = 0;

    // Reference: doubling mod 2^W plus the parity of the tapped bits
    function automatic int nxt(input int s);
        int fb;
        fb = $countones(s & int'(TP)) % 2;
        return (s * 2 + fb) % (1 << W);
    endfunction

    task automatic drive(input bit r, input bit l, input int sd,
                         input bit e, input bit s, input int c);
        bit stp;
        rst   = r;
        load  = l;
        seed  = W'(sd);
        en    = e;
        start = s;
        count = CW'(c);
        stp   = 0;
        if (r) begin
            m_state = 1; m_ref = 1; m_run = 0; m_done = 0; m_wrap = 0;
        end else if (l) begin
            m_state = (sd % (1 << W) == 0) ? 1 : sd % (1 << W);
            m_ref = m_state; m_run = 0; m_done = 0; m_wrap = 0;
        end else begin
            m_done = 0;
            if (m_run) begin
                stp = 1;
                m_left--;
                if (m_left == 0) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end else if (s) begin
                if (c == 0) m_done = 1;
                else begin
                    m_run  = 1;
                    m_left = c;
                end
            end else if (e) begin
                stp = 1;
            end
            if (stp) m_state = nxt(m_state);
            m_wrap = MON && stp && (m_state == m_ref);
        end
        q.push_back(exp_t'{d: W'(m_state), b: m_run, dn: m_done, wr: m_wrap});
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input bit e);
        drive(0, 0, 0, e, 0, 0);
    endtask

    task automatic chk(input string nm, input int act, input int ex);
        vectors++;
        if (act != ex) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, ex);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            vectors++;
            if ({data_out, busy, done, wrap} !== x) begin
                errors++;
                $display("FAIL sb @%0t: got d=%h b=%b dn=%b w=%b want d=%h b=%b dn=%b w=%b",
                         $time, data_out, busy, done, wrap, x.d, x.b, x.dn, x.wr);
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $fatal(1, "timeout");
    end

    int fr_exp[5] = '{2, 4, 9, 3, 6};

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("rst_data", data_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);

        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("freerun", data_out, fr_exp[i]);
        end
        repeat (10) idle(1);
        chk("period15", data_out, 1);

        drive(0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 5);
        chk("run_busy0", busy, 1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("run_busy", busy, 1);
            chk("run_nodone", done, 0);
        end
        idle(1);
        chk("run_end_busy", busy, 0);
        chk("run_done", done, 1);
        chk("run_data", data_out, 6);
        idle(0);
        chk("done_pulse", done, 0);

        drive(0, 0, 0, 0, 1, 0);
        chk("cnt0_done", done, 1);
        chk("cnt0_busy", busy, 0);
        chk("cnt0_data", data_out, 6);

        drive(0, 1, 0, 0, 0, 0);
        chk("zero_seed", data_out, 1);

        drive(0, 0, 0, 0, 1, 10);
        idle(0);
        idle(0);
        chk("abort_busy3", busy, 1);
        drive(0, 1, 10, 0, 0, 0);
        chk("abort_data", data_out, 10);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        idle(0);
        chk("abort_nodone", done, 0);

        drive(1, 1, 7, 0, 1, 3);
        chk("prio_rst_data", data_out, 1);
        chk("prio_rst_busy", busy, 0);
        drive(0, 1, 5, 0, 1, 3);
        chk("prio_load_data", data_out, 5);
        idle(0);
        chk("prio_load_busy", busy, 0);
        chk("prio_load_hold", data_out, 5);

        drive(0, 1, 9, 0, 0, 0);
        for (int i = 1; i <= 30; i++) begin
            idle(1);
            if (i == 14 || i == 15 || i == 30)
                chk("wrap", wrap, (i == 14) ? 0 : int'(MON));
        end
        chk("wrap_state", data_out, 9);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 40) == 0,
                  ($urandom % 10) == 0,
                  (($urandom % 8) == 0) ? 0 : int'($urandom % 16),
                  $urandom % 2,
                  ($urandom % 8) == 0,
                  int'($urandom_range(0, 20)));
        end
        idle(0);

        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
